// File: rtl/wb_port_driver_if.sv
// Writeback port bundle: ALU result, load result handshake, load-issue
// scoreboard and the register file write port.
interface wb_port_driver_if;
    logic        alu_valid;
    logic [4:0]  alu_dst;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_dst;
    logic [31:0] ld_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_dst;
    logic [31:0] busy;
    logic [4:0]  a3;
    logic [31:0] wr;
    logic        wrenable;

    modport master (
        output alu_valid, alu_dst, alu_data,
        output ld_valid, ld_dst, ld_data,
        output ld_issue, ld_issue_dst,
        input  ld_ready, busy, a3, wr, wrenable
    );

    modport slave (
        input  alu_valid, alu_dst, alu_data,
        input  ld_valid, ld_dst, ld_data,
        input  ld_issue, ld_issue_dst,
        output ld_ready, busy, a3, wr, wrenable
    );
endinterface

// File: rtl/wb_port_driver.sv
// Register file writeback driver: ALU results take priority, load results queue in a FIFO.
// Optional WB_ZERO_REG_FILTER_EN drops writes and pending bits aimed at r0.
module wb_port_driver #(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_driver_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [36:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [36:0]   head;

    logic        alu_take;
    logic        ld_keep;
    logic        issue_ok;
    logic        push;
    logic        pop;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

`ifdef WB_ZERO_REG_FILTER_EN
    assign alu_take = bus.alu_valid && (bus.alu_dst != 5'd0);
    assign ld_keep  = (bus.ld_dst != 5'd0);
    assign issue_ok = bus.ld_issue && (bus.ld_issue_dst != 5'd0);
`else
    assign alu_take = bus.alu_valid;
    assign ld_keep  = 1'b1;
    assign issue_ok = bus.ld_issue;
`endif

    // Ready is gated by reset so it reads 0 throughout reset and 1 immediately after.
    assign bus.ld_ready = !reset && (count != FULL_CNT);

    assign push     = bus.ld_valid && bus.ld_ready && ld_keep;
    assign pop      = !alu_take && (count != '0);
    assign head     = mem[rd_ptr];
    assign set_mask = issue_ok ? (32'd1 << bus.ld_issue_dst) : 32'd0;
    assign clr_mask = pop ? (32'd1 << head[36:32]) : 32'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.ld_dst, bus.ld_data};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            bus.a3       <= 5'd0;
            bus.wr       <= 32'd0;
            bus.wrenable <= 1'b0;
            bus.busy     <= 32'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (alu_take) begin
                bus.a3       <= bus.alu_dst;
                bus.wr       <= bus.alu_data;
                bus.wrenable <= 1'b1;
            end else if (pop) begin
                bus.a3       <= head[36:32];
                bus.wr       <= head[31:0];
                bus.wrenable <= 1'b1;
            end else begin
                bus.wrenable <= 1'b0;
            end

            // Issue set is applied after the load-write clear so set wins on collision.
            bus.busy <= (bus.busy & ~clr_mask) | set_mask;
        end
    end
endmodule

// File: tb/tb_wb_port_driver.sv
// Directed bench for wb_port_driver: ALU path, scoreboard, priority/backpressure,
// simultaneous events, mid-operation reset and r0 handling (WB_ZERO_REG_FILTER_EN aware).
module tb_wb_port_driver;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wb_port_driver_if bus ();

    wb_port_driver #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid    = 1'b0;
        bus.alu_dst      = 5'd0;
        bus.alu_data     = 32'd0;
        bus.ld_valid     = 1'b0;
        bus.ld_dst       = 5'd0;
        bus.ld_data      = 32'd0;
        bus.ld_issue     = 1'b0;
        bus.ld_issue_dst = 5'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL reset_wrenable got %b want 0", bus.wrenable); end
        checks++; if (bus.a3 !== 5'd0) begin errors++; $display("FAIL reset_a3 got %0d want 0", bus.a3); end
        checks++; if (bus.wr !== 32'd0) begin errors++; $display("FAIL reset_wr got %h want 0", bus.wr); end
        checks++; if (bus.busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", bus.busy); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got %b want 0", bus.ld_ready); end
        tick();
    endtask

    task automatic test_alu();
        reset         = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_dst   = 5'd5;
        bus.alu_data  = 32'hDEADBEEF;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ld_ready got %b want 1", bus.ld_ready); end
        checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL alu_early got %b want 0", bus.wrenable); end
        tick();
        bus.alu_valid = 1'b0;
        checks++; if (bus.wrenable !== 1'b1) begin errors++; $display("FAIL alu_wrenable got %b want 1", bus.wrenable); end
        checks++; if (bus.a3 !== 5'd5) begin errors++; $display("FAIL alu_a3 got %0d want 5", bus.a3); end
        checks++; if (bus.wr !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wr got %h want deadbeef", bus.wr); end
        tick();
        checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL alu_one_cycle got %b want 0", bus.wrenable); end
        checks++; if (bus.a3 !== 5'd5 || bus.wr !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_hold got %0d/%h want 5/deadbeef", bus.a3, bus.wr); end
    endtask

    task automatic test_scoreboard();
        bus.ld_issue     = 1'b1;
        bus.ld_issue_dst = 5'd7;
        tick();
        bus.ld_issue = 1'b0;
        checks++; if (bus.busy !== 32'h0000_0080) begin errors++; $display("FAIL sb_set got %h want 00000080", bus.busy); end
        tick();
        tick();
        bus.ld_valid = 1'b1;
        bus.ld_dst   = 5'd7;
        bus.ld_data  = 32'h12;
        tick();
        bus.ld_valid = 1'b0;
        checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL sb_no_early_write got %b want 0", bus.wrenable); end
        checks++; if (bus.busy[7] !== 1'b1) begin errors++; $display("FAIL sb_still_busy got %b want 1", bus.busy[7]); end
        tick();
        checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'd7 || bus.wr !== 32'h12) begin errors++; $display("FAIL sb_load_write got %b/%0d/%h want 1/7/12", bus.wrenable, bus.a3, bus.wr); end
        checks++; if (bus.busy !== 32'd0) begin errors++; $display("FAIL sb_clear got %h want 0", bus.busy); end
        tick();
        checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL sb_single_write got %b want 0", bus.wrenable); end
    endtask

    task automatic test_priority_backpressure();
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_dst   = 5'(10 + i);
            bus.alu_data  = 32'(1000 + i);
            bus.ld_valid  = 1'b1;
            bus.ld_dst    = 5'(1 + i);
            bus.ld_data   = 32'(100 + i);
            #1;
            checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_before_full[%0d] got %b want 1", i, bus.ld_ready); end
            tick();
            checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'(10 + i) || bus.wr !== 32'(1000 + i)) begin errors++; $display("FAIL bp_alu_write[%0d] got %b/%0d/%0d want 1/%0d/%0d", i, bus.wrenable, bus.a3, bus.wr, 10 + i, 1000 + i); end
        end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", bus.ld_ready); end
        bus.alu_dst  = 5'd20;
        bus.alu_data = 32'd2000;
        bus.ld_dst   = 5'd9;
        bus.ld_data  = 32'd999;
        tick();
        checks++; if (bus.a3 !== 5'd20 || bus.wr !== 32'd2000) begin errors++; $display("FAIL bp_alu_while_full got %0d/%0d want 20/2000", bus.a3, bus.wr); end
        checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL bp_stay_full got %b want 0", bus.ld_ready); end
        bus.alu_valid = 1'b0;
        bus.ld_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'(1 + i) || bus.wr !== 32'(100 + i)) begin errors++; $display("FAIL bp_drain[%0d] got %b/%0d/%0d want 1/%0d/%0d", i, bus.wrenable, bus.a3, bus.wr, 1 + i, 100 + i); end
            checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop[%0d] got %b want 1", i, bus.ld_ready); end
        end
        tick();
        checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL bp_no_extra_write got %b/%0d want 0", bus.wrenable, bus.a3); end
    endtask

    task automatic test_simultaneous();
        bus.ld_issue     = 1'b1;
        bus.ld_issue_dst = 5'd3;
        tick();
        bus.ld_issue = 1'b0;
        checks++; if (bus.busy[3] !== 1'b1) begin errors++; $display("FAIL sim_busy_set got %b want 1", bus.busy[3]); end
        bus.ld_valid = 1'b1;
        bus.ld_dst   = 5'd3;
        bus.ld_data  = 32'd33;
        tick();
        bus.ld_valid     = 1'b0;
        bus.ld_issue     = 1'b1;
        bus.ld_issue_dst = 5'd3;
        tick();
        bus.ld_issue = 1'b0;
        checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'd3 || bus.wr !== 32'd33) begin errors++; $display("FAIL sim_load_write got %b/%0d/%0d want 1/3/33", bus.wrenable, bus.a3, bus.wr); end
        checks++; if (bus.busy[3] !== 1'b1) begin errors++; $display("FAIL sim_set_wins got %b want 1", bus.busy[3]); end
        bus.ld_valid = 1'b1;
        bus.ld_dst   = 5'd20;
        bus.ld_data  = 32'd1;
        tick();
        bus.ld_dst  = 5'd21;
        bus.ld_data = 32'd2;
        tick();
        bus.ld_valid = 1'b0;
        checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'd20 || bus.wr !== 32'd1) begin errors++; $display("FAIL sim_pushpop_pop got %b/%0d/%0d want 1/20/1", bus.wrenable, bus.a3, bus.wr); end
        tick();
        checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'd21 || bus.wr !== 32'd2) begin errors++; $display("FAIL sim_pushpop_kept got %b/%0d/%0d want 1/21/2", bus.wrenable, bus.a3, bus.wr); end
        tick();
        checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL sim_pushpop_count got %b/%0d want 0", bus.wrenable, bus.a3); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid    = 1'b1;
            bus.alu_dst      = 5'd15;
            bus.alu_data     = 32'd15;
            bus.ld_valid     = 1'b1;
            bus.ld_dst       = 5'(12 + i);
            bus.ld_data      = 32'(12 + i);
            bus.ld_issue     = (i == 0);
            bus.ld_issue_dst = 5'd11;
            tick();
        end
        idle_inputs();
        checks++; if (bus.busy === 32'd0) begin errors++; $display("FAIL rm_busy_before got %h want nonzero", bus.busy); end
        reset = 1'b1;
        tick();
        checks++; if (bus.wrenable !== 1'b0 || bus.a3 !== 5'd0 || bus.wr !== 32'd0) begin errors++; $display("FAIL rm_outputs got %b/%0d/%h want 0/0/0", bus.wrenable, bus.a3, bus.wr); end
        checks++; if (bus.busy !== 32'd0) begin errors++; $display("FAIL rm_busy got %h want 0", bus.busy); end
        reset = 1'b0;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", bus.ld_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL rm_no_write[%0d] got %b/%0d want 0", i, bus.wrenable, bus.a3); end
        end
    endtask

    task automatic test_zero_reg();
        bus.ld_issue     = 1'b1;
        bus.ld_issue_dst = 5'd0;
        tick();
        bus.ld_issue = 1'b0;
`ifdef WB_ZERO_REG_FILTER_EN
        checks++; if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL zr_busy0 got %b want 0", bus.busy[0]); end
`else
        checks++; if (bus.busy[0] !== 1'b1) begin errors++; $display("FAIL zr_busy0 got %b want 1", bus.busy[0]); end
`endif
        bus.ld_valid = 1'b1;
        bus.ld_dst   = 5'd9;
        bus.ld_data  = 32'd99;
        tick();
        bus.ld_valid  = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_dst   = 5'd0;
        bus.alu_data  = 32'd5;
        tick();
        bus.alu_valid = 1'b0;
`ifdef WB_ZERO_REG_FILTER_EN
        checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'd9 || bus.wr !== 32'd99) begin errors++; $display("FAIL zr_slot_freed got %b/%0d/%0d want 1/9/99", bus.wrenable, bus.a3, bus.wr); end
        tick();
        checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL zr_after got %b want 0", bus.wrenable); end
`else
        checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'd0 || bus.wr !== 32'd5) begin errors++; $display("FAIL zr_alu_r0 got %b/%0d/%0d want 1/0/5", bus.wrenable, bus.a3, bus.wr); end
        tick();
        checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'd9 || bus.wr !== 32'd99) begin errors++; $display("FAIL zr_load_r9 got %b/%0d/%0d want 1/9/99", bus.wrenable, bus.a3, bus.wr); end
`endif
        tick();
        bus.ld_valid = 1'b1;
        bus.ld_dst   = 5'd0;
        bus.ld_data  = 32'd77;
        #1;
        checks++; if (bus.ld_ready !== 1'b1) begin errors++; $display("FAIL zr_ld_ready got %b want 1", bus.ld_ready); end
        tick();
        bus.ld_valid = 1'b0;
        tick();
`ifdef WB_ZERO_REG_FILTER_EN
        checks++; if (bus.wrenable !== 1'b0) begin errors++; $display("FAIL zr_load_r0 got %b/%0d want 0", bus.wrenable, bus.a3); end
`else
        checks++; if (bus.wrenable !== 1'b1 || bus.a3 !== 5'd0 || bus.wr !== 32'd77) begin errors++; $display("FAIL zr_load_r0 got %b/%0d/%0d want 1/0/77", bus.wrenable, bus.a3, bus.wr); end
        checks++; if (bus.busy[0] !== 1'b0) begin errors++; $display("FAIL zr_busy0_clear got %b want 0", bus.busy[0]); end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu();
        test_scoreboard();
        test_priority_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_zero_reg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
